pic_ack_sequencer: RTL and testbench

Interrupt-acknowledge controller for the 8259A PIC. It watches the unmasked requests coming from the Interrupt Request Register and raises INT. It then sequences the two-pulse INTA handshake: freeze priority, clear the IRR bit, set the ISR bit, and drive the vector onto the data buffer. It also owns the In-Service Register and applies EOI/AEOI clears.

---
 rtl/pic_ack_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pic_ack_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_sequencer.sv
// 8259A interrupt-acknowledge sequencer: raises INT, runs the two-pulse INTA
// handshake, owns the In-Service Register and applies EOI/AEOI clears.
module pic_ack_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] risedBits,
    input  logic [4:0] icw2VectorBase,
    input  logic       aeoiMode,
    input  logic       eoiStrobe,
    input  logic       eoiSpecific,
    input  logic [2:0] eoiLevel,
    input  logic       inta_n,
    output logic       INT,
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic       resetIRRValid,
    output logic [7:0] ISR,
    output logic [7:0] dataBuffer,
    output logic       dataBufferEnable
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_WAIT2 = 2'd2;
    localparam logic [1:0] S_ACK2  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_inta_q;
    logic [2:0]       level_q, level_d;
    logic             spur_q, spur_d;
    logic [7:0]       isr_q, isr_d;
    logic             int_q, int_d;
    logic             rp_q, rp_d;
    logic [2:0]       rirr_q, rirr_d;
    logic             rv_q, rv_d;
    logic [7:0]       db_q, db_d;
    logic             dbe_q, dbe_d;

    logic [3:0] isr_top;
    logic [2:0] winner;
    logic       winner_vld;
    logic       fall, rise;
    logic [7:0] isr_set, aeoi_clr, eoi_clr;

    assign fall = prev_inta_q & ~inta_n;
    assign rise = ~prev_inta_q & inta_n;

    // Fixed priority, IR0 highest; isr_top = 8 means nothing in service.
    always_comb begin
        isr_top = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (isr_q[i]) isr_top = 4'(i);
        end
    end

    always_comb begin
        winner     = 3'd0;
        winner_vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (risedBits[i] && (4'(i) < isr_top)) begin
                winner     = 3'(i);
                winner_vld = 1'b1;
            end
        end
    end

    always_comb begin
        eoi_clr = 8'd0;
        if (eoiStrobe) begin
            if (eoiSpecific)
                eoi_clr[eoiLevel] = 1'b1;
            else if (!isr_top[3])
                eoi_clr[isr_top[2:0]] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        spur_d   = spur_q;
        rp_d     = 1'b0;
        rv_d     = 1'b0;
        rirr_d   = rirr_q;
        db_d     = db_q;
        dbe_d    = dbe_q;
        isr_set  = 8'd0;
        aeoi_clr = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (winner_vld) state_d = S_PEND;
            end
            S_PEND: begin
                if (fall) begin
                    rp_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT2;
                    if (winner_vld) begin
                        isr_set[winner] = 1'b1;
                        rirr_d  = winner;
                        rv_d    = 1'b1;
                        level_d = winner;
                        spur_d  = 1'b0;
                    end else begin
                        // Request vanished before ACK1: answer with IR7 vector, touch nothing.
                        level_d = 3'd7;
                        spur_d  = 1'b1;
                    end
                end
            end
            S_WAIT2: begin
                cnt_d = cnt_q + 1'b1;
                if (fall) begin
                    db_d    = {icw2VectorBase, level_q};
                    dbe_d   = 1'b1;
                    state_d = S_ACK2;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK2: begin
                if (rise) begin
                    db_d    = 8'd0;
                    dbe_d   = 1'b0;
                    state_d = S_IDLE;
                    if (aeoiMode && !spur_q) aeoi_clr[level_q] = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A same-edge ACK1 set beats any clear of that bit.
        isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;
        int_d = (state_d == S_PEND);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prev_inta_q <= 1'b1;
            level_q     <= 3'd0;
            spur_q      <= 1'b0;
            isr_q       <= 8'd0;
            int_q       <= 1'b0;
            rp_q        <= 1'b0;
            rirr_q      <= 3'd0;
            rv_q        <= 1'b0;
            db_q        <= 8'd0;
            dbe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_inta_q <= inta_n;
            level_q     <= level_d;
            spur_q      <= spur_d;
            isr_q       <= isr_d;
            int_q       <= int_d;
            rp_q        <= rp_d;
            rirr_q      <= rirr_d;
            rv_q        <= rv_d;
            db_q        <= db_d;
            dbe_q       <= dbe_d;
        end
    end

    assign INT              = int_q;
    assign readPriority     = rp_q;
    assign resetIRR         = rirr_q;
    assign resetIRRValid    = rv_q;
    assign ISR              = isr_q;
    assign dataBuffer       = db_q;
    assign dataBufferEnable = dbe_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Bench for pic_ack_sequencer: vector table plus hand-driven timeout and
// mid-cycle reset sequences, checked through an expected-output queue.
module tb_pic_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] risedBits;
    logic [4:0] icw2VectorBase;
    logic       aeoiMode, eoiStrobe, eoiSpecific, inta_n;
    logic [2:0] eoiLevel;
    logic       int_s, rp_s, rv_s, dbe_s;
    logic [2:0] rirr_s;
    logic [7:0] isr_s, db_s;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        logic       intv;
        logic [7:0] isr;
        logic       rp;
        logic       rv;
        logic [2:0] rirr;
        logic [7:0] db;
        logic       dbe;
    } exp_t;

    typedef struct {
        logic [7:0] rb;
        logic [4:0] base;
        logic       aeoi, eoi, spec;
        logic [2:0] lvl;
        logic       inta;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    pic_ack_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .risedBits(risedBits),
        .icw2VectorBase(icw2VectorBase), .aeoiMode(aeoiMode),
        .eoiStrobe(eoiStrobe), .eoiSpecific(eoiSpecific), .eoiLevel(eoiLevel),
        .inta_n(inta_n), .INT(int_s), .readPriority(rp_s), .resetIRR(rirr_s),
        .resetIRRValid(rv_s), .ISR(isr_s), .dataBuffer(db_s),
        .dataBufferEnable(dbe_s)
    );

    always #5 clk = ~clk;

    function automatic exp_t mke(logic i, logic [7:0] s, logic p, logic v,
                                 logic [2:0] r, logic [7:0] d, logic de);
        exp_t e;
        e.intv = i; e.isr = s; e.rp = p; e.rv = v; e.rirr = r; e.db = d; e.dbe = de;
        return e;
    endfunction

    function automatic vec_t mk(logic [7:0] rb, logic [4:0] base, logic aeoi,
                                logic eoi, logic spec, logic [2:0] lvl, logic inta,
                                logic i, logic [7:0] s, logic p, logic v,
                                logic [2:0] r, logic [7:0] d, logic de);
        vec_t t;
        t.rb = rb; t.base = base; t.aeoi = aeoi; t.eoi = eoi; t.spec = spec;
        t.lvl = lvl; t.inta = inta; t.e = mke(i, s, p, v, r, d, de);
        return t;
    endfunction

    task automatic chk(string tag, string fld, logic [7:0] act, logic [7:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s %s: got %0h expected %0h", tag, fld, act, exp);
    endtask

    task automatic check_front(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            ntot++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk(tag, "INT",   {7'd0, int_s}, {7'd0, e.intv});
        chk(tag, "ISR",   isr_s,         e.isr);
        chk(tag, "rdPri", {7'd0, rp_s},  {7'd0, e.rp});
        chk(tag, "rirrV", {7'd0, rv_s},  {7'd0, e.rv});
        chk(tag, "rirr",  {5'd0, rirr_s}, {5'd0, e.rirr});
        chk(tag, "dbuf",  db_s,          e.db);
        chk(tag, "dbufE", {7'd0, dbe_s}, {7'd0, e.dbe});
    endtask

    task automatic step(vec_t v, string tag);
        risedBits = v.rb; icw2VectorBase = v.base; aeoiMode = v.aeoi;
        eoiStrobe = v.eoi; eoiSpecific = v.spec; eoiLevel = v.lvl; inta_n = v.inta;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        check_front(tag);
    endtask

    localparam logic [4:0] B = 5'h08;
    localparam logic [4:0] F = 5'h1F;

    initial begin
        // basic 8086 cycle
        vecs.push_back(mk(8'h24,B,0,0,0,0,1, 1,8'h00,0,0,0,8'h00,0));
        vecs.push_back(mk(8'h24,B,0,0,0,0,0, 0,8'h04,1,1,2,8'h00,0));
        vecs.push_back(mk(8'h24,B,0,0,0,0,1, 0,8'h04,0,0,2,8'h00,0));
        vecs.push_back(mk(8'h24,B,0,0,0,0,0, 0,8'h04,0,0,2,8'h42,1));
        vecs.push_back(mk(8'h24,B,0,0,0,0,0, 0,8'h04,0,0,2,8'h42,1));
        vecs.push_back(mk(8'h24,B,0,0,0,0,1, 0,8'h04,0,0,2,8'h00,0));
        vecs.push_back(mk(8'h24,B,0,0,0,0,1, 0,8'h04,0,0,2,8'h00,0));
        vecs.push_back(mk(8'h24,B,0,1,0,0,1, 0,8'h00,0,0,2,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,0,0,0,1, 0,8'h00,0,0,2,8'h00,0));
        // AEOI
        vecs.push_back(mk(8'h80,F,1,0,0,0,1, 1,8'h00,0,0,2,8'h00,0));
        vecs.push_back(mk(8'h80,F,1,0,0,0,0, 0,8'h80,1,1,7,8'h00,0));
        vecs.push_back(mk(8'h80,F,1,0,0,0,1, 0,8'h80,0,0,7,8'h00,0));
        vecs.push_back(mk(8'h80,F,1,0,0,0,0, 0,8'h80,0,0,7,8'hFF,1));
        vecs.push_back(mk(8'h00,F,1,0,0,0,1, 0,8'h00,0,0,7,8'h00,0));
        vecs.push_back(mk(8'h00,F,1,0,0,0,1, 0,8'h00,0,0,7,8'h00,0));
        // spurious
        vecs.push_back(mk(8'h10,B,0,0,0,0,1, 1,8'h00,0,0,7,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,0,0,0,1, 1,8'h00,0,0,7,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,0,0,0,0, 0,8'h00,1,0,7,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,0,0,0,1, 0,8'h00,0,0,7,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,0,0,0,0, 0,8'h00,0,0,7,8'h47,1));
        vecs.push_back(mk(8'h00,B,1,0,0,0,1, 0,8'h00,0,0,7,8'h00,0));
        // nesting and priority blocking
        vecs.push_back(mk(8'h08,B,0,0,0,0,1, 1,8'h00,0,0,7,8'h00,0));
        vecs.push_back(mk(8'h08,B,0,0,0,0,0, 0,8'h08,1,1,3,8'h00,0));
        vecs.push_back(mk(8'h08,B,0,0,0,0,1, 0,8'h08,0,0,3,8'h00,0));
        vecs.push_back(mk(8'h08,B,0,0,0,0,0, 0,8'h08,0,0,3,8'h43,1));
        vecs.push_back(mk(8'h30,B,0,0,0,0,1, 0,8'h08,0,0,3,8'h00,0));
        vecs.push_back(mk(8'h30,B,0,0,0,0,1, 0,8'h08,0,0,3,8'h00,0));
        vecs.push_back(mk(8'h30,B,0,0,0,0,1, 0,8'h08,0,0,3,8'h00,0));
        vecs.push_back(mk(8'h02,B,0,0,0,0,1, 1,8'h08,0,0,3,8'h00,0));
        vecs.push_back(mk(8'h02,B,0,0,0,0,0, 0,8'h0A,1,1,1,8'h00,0));
        vecs.push_back(mk(8'h02,B,0,0,0,0,1, 0,8'h0A,0,0,1,8'h00,0));
        vecs.push_back(mk(8'h02,B,0,0,0,0,0, 0,8'h0A,0,0,1,8'h41,1));
        vecs.push_back(mk(8'h00,B,0,0,0,0,1, 0,8'h0A,0,0,1,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,1,1,1,1, 0,8'h08,0,0,1,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,1,0,0,1, 0,8'h00,0,0,1,8'h00,0));
        // ACK1 set collides with specific EOI on the same bit
        vecs.push_back(mk(8'h04,B,0,0,0,0,1, 1,8'h00,0,0,1,8'h00,0));
        vecs.push_back(mk(8'h04,B,0,1,1,2,0, 0,8'h04,1,1,2,8'h00,0));
        vecs.push_back(mk(8'h04,B,0,0,0,0,1, 0,8'h04,0,0,2,8'h00,0));
        vecs.push_back(mk(8'h04,B,0,0,0,0,0, 0,8'h04,0,0,2,8'h42,1));
        vecs.push_back(mk(8'h00,B,0,0,0,0,1, 0,8'h04,0,0,2,8'h00,0));
        vecs.push_back(mk(8'h00,B,0,1,0,0,1, 0,8'h00,0,0,2,8'h00,0));

        reset_n = 1'b0; risedBits = 8'h00; icw2VectorBase = B; aeoiMode = 1'b0;
        eoiStrobe = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0; inta_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mke(0, 8'h00, 0, 0, 0, 8'h00, 0));
        check_front("reset");
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("row%0d", i));

        // timeout: ACK1 on IR5, then no second INTA; IR0 can only raise INT once back in IDLE
        step(mk(8'h20,B,0,0,0,0,1, 1,8'h00,0,0,2,8'h00,0), "to_int");
        step(mk(8'h20,B,0,0,0,0,0, 0,8'h20,1,1,5,8'h00,0), "to_ack1");
        for (int k = 1; k <= 64; k++)
            step(mk(8'h01,B,0,0,0,0,1, 0,8'h20,0,0,5,8'h00,0), $sformatf("to_wait%0d", k));
        step(mk(8'h01,B,0,0,0,0,1, 1,8'h20,0,0,5,8'h00,0), "to_idle");

        // nested IR0 cycle, then async reset while the vector is on the bus
        step(mk(8'h01,B,0,0,0,0,0, 0,8'h21,1,1,0,8'h00,0), "rst_ack1");
        step(mk(8'h01,B,0,0,0,0,1, 0,8'h21,0,0,0,8'h00,0), "rst_wait");
        step(mk(8'h01,B,0,0,0,0,0, 0,8'h21,0,0,0,8'h40,1), "rst_ack2");
        #2 reset_n = 1'b0;
        #1;
        sb.push_back(mke(0, 8'h00, 0, 0, 0, 8'h00, 0));
        check_front("rst_async");
        risedBits = 8'h00; inta_n = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(mk(8'h00,B,0,0,0,0,1, 0,8'h00,0,0,0,8'h00,0), "rst_idle");
        step(mk(8'h01,B,0,0,0,0,1, 1,8'h00,0,0,0,8'h00,0), "rst_reint");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
